// File: rtl/microprocessor_core.sv
// Single-cycle RV32I subset core: ALU ops, LUI, branches and JAL.
// The instruction word arrives each cycle; one instruction retires per rising edge.

module microprocessor_core_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned AW         = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [AW-1:0]         ra1_i,
    input  logic [AW-1:0]         ra2_i,
    output logic [DATA_WIDTH-1:0] rd1_o,
    output logic [DATA_WIDTH-1:0] rd2_o,
    input  logic                  we_i,
    input  logic [AW-1:0]         wa_i,
    input  logic [DATA_WIDTH-1:0] wd_i
);

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

    // Write-back; x0 is never written, so its storage stays at the reset value.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

module microprocessor_core #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          REG_COUNT  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(32'h0000_0000)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] alu_result
);

    localparam int unsigned AW  = $clog2(REG_COUNT);
    localparam int unsigned SHW = $clog2(DATA_WIDTH);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} sel_a_e;
    typedef enum logic [1:0] {B_RS2, B_IMM_I, B_IMM_U, B_FOUR} sel_b_e;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_idx;
    logic [4:0] rs1_idx;
    logic [4:0] rs2_idx;

    assign opcode  = instruction[6:0];
    assign rd_idx  = instruction[11:7];
    assign funct3  = instruction[14:12];
    assign rs1_idx = instruction[19:15];
    assign rs2_idx = instruction[24:20];
    assign funct7  = instruction[31:25];

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] imm_b;
    logic [DATA_WIDTH-1:0] imm_j;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu_c;
    logic [SHW-1:0]        shamt;

    alu_op_e alu_op;
    sel_a_e  sel_a;
    sel_b_e  sel_b;
    logic    reg_we;
    logic    is_branch;
    logic    is_jal;
    logic    br_cond;
    logic    br_taken;

    function automatic alu_op_e f3_to_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Immediate generator
    assign imm_i = {{(DATA_WIDTH-12){instruction[31]}}, instruction[31:20]};
    assign imm_u = {{(DATA_WIDTH-32){instruction[31]}}, instruction[31:12], 12'b0};
    assign imm_b = {{(DATA_WIDTH-12){instruction[31]}}, instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign imm_j = {{(DATA_WIDTH-20){instruction[31]}}, instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};

    // Control unit; anything not explicitly decoded falls through as a NOP.
    always_comb begin
        reg_we    = 1'b0;
        alu_op    = ALU_ADD;
        sel_a     = A_RS1;
        sel_b     = B_IMM_I;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        case (opcode)
            OP_R: begin
                sel_b = B_RS2;
                if (funct7 == F7_BASE) begin
                    reg_we = 1'b1;
                    alu_op = f3_to_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    reg_we = 1'b1;
                    alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    reg_we = 1'b1;
                    alu_op = ALU_SRA;
                end
            end
            OP_I: begin
                reg_we = 1'b1;
                alu_op = f3_to_op(funct3);
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    reg_we = 1'b0;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        alu_op = ALU_SRA;
                    end else if (funct7 != F7_BASE) begin
                        reg_we = 1'b0;
                    end
                end
            end
            OP_LUI: begin
                reg_we = 1'b1;
                sel_a  = A_ZERO;
                sel_b  = B_IMM_U;
            end
            OP_BR: begin
                alu_op    = ALU_SUB;
                sel_b     = B_RS2;
                is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OP_JAL: begin
                reg_we = 1'b1;
                is_jal = 1'b1;
                sel_a  = A_PC;
                sel_b  = B_FOUR;
            end
            default: ;
        endcase
    end

    microprocessor_core_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .AW         (AW)
    ) u_regfile (
        .clk    (clk),
        .arst_n (arst_n),
        .ra1_i  (AW'(rs1_idx)),
        .ra2_i  (AW'(rs2_idx)),
        .rd1_o  (rs1_data),
        .rd2_o  (rs2_data),
        .we_i   (reg_we),
        .wa_i   (AW'(rd_idx)),
        .wd_i   (alu_c)
    );

    // Operand muxes
    always_comb begin
        op_a = rs1_data;
        op_b = imm_i;
        case (sel_a)
            A_PC:    op_a = pc_q;
            A_ZERO:  op_a = '0;
            default: op_a = rs1_data;
        endcase
        case (sel_b)
            B_RS2:   op_b = rs2_data;
            B_IMM_U: op_b = imm_u;
            B_FOUR:  op_b = DATA_WIDTH'(4);
            default: op_b = imm_i;
        endcase
    end

    assign shamt = op_b[SHW-1:0];

    // ALU
    always_comb begin
        alu_c = '0;
        case (alu_op)
            ALU_ADD:  alu_c = op_a + op_b;
            ALU_SUB:  alu_c = op_a - op_b;
            ALU_SLL:  alu_c = op_a << shamt;
            ALU_SLT:  alu_c = DATA_WIDTH'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_c = DATA_WIDTH'(op_a < op_b);
            ALU_XOR:  alu_c = op_a ^ op_b;
            ALU_SRL:  alu_c = op_a >> shamt;
            ALU_SRA:  alu_c = DATA_WIDTH'($signed(op_a) >>> shamt);
            ALU_OR:   alu_c = op_a | op_b;
            ALU_AND:  alu_c = op_a & op_b;
            default:  alu_c = '0;
        endcase
    end

    // Branch condition straight from the register operands
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (rs1_data == rs2_data);
            3'b001:  br_cond = (rs1_data != rs2_data);
            3'b100:  br_cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  br_cond = (rs1_data <  rs2_data);
            3'b111:  br_cond = (rs1_data >= rs2_data);
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken = is_branch && br_cond;

    // Next-PC mux
    always_comb begin
        pc_d = pc_q + DATA_WIDTH'(4);
        if (br_taken) begin
            pc_d = pc_q + imm_b;
        end else if (is_jal) begin
            pc_d = pc_q + imm_j;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc         = pc_q;
    assign alu_result = alu_c;

endmodule

// File: tb/tb_microprocessor_core.sv
// Directed bench for microprocessor_core: drives instruction words and checks
// pc / alu_result; register contents are observed via ADDI x0,xN,0 reads.

module tb_microprocessor_core;

    logic        clk;
    logic        arst_n;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] alu_result;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;

    microprocessor_core #(
        .DATA_WIDTH (32),
        .REG_COUNT  (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .instruction (instruction),
        .pc          (pc),
        .alu_result  (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'h13};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd);
        return {20'(imm20), 5'(rd), 7'h37};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] im;
        im = 21'(imm);
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Present one instruction, check pc and (optionally) alu_result, then retire it.
    task automatic step(input logic [31:0] instr, input logic [31:0] exp_alu,
                        input logic [31:0] next_pc, input bit chk_alu, input string tag);
        instruction = instr;
        #1;
        check({tag, ".pc"}, pc, exp_pc);
        if (chk_alu) check({tag, ".alu"}, alu_result, exp_alu);
        @(posedge clk);
        #2;
        exp_pc = next_pc;
    endtask

    task automatic alu_step(input logic [31:0] instr, input logic [31:0] exp_alu, input string tag);
        step(instr, exp_alu, exp_pc + 32'd4, 1'b1, tag);
    endtask

    task automatic peek(input int r, input logic [31:0] exp_val, input string tag);
        step(enc_i(0, r, 0, 0), exp_val, exp_pc + 32'd4, 1'b1, tag);
    endtask

    initial begin
        int          fib [10] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89};
        logic [31:0] prev_x2;
        logic [31:0] loop_pc;
        logic [31:0] jp;

        arst_n      = 1'b0;
        instruction = 32'h0000_0513;
        exp_pc      = 32'h0;
        #2;
        check("rst.pc", pc, 32'h0);
        check("rst.alu", alu_result, 32'h0);
        #4;
        check("rst.pc_held_over_edge", pc, 32'h0);
        #1;
        arst_n = 1'b1;

        for (int k = 0; k < 4; k++) alu_step(32'h0000_0513, 32'h0, "nop_addi");
        step(enc_b(-8, 0, 0, 0), 32'h0, 32'h8, 1'b1, "beq_back");

        alu_step(enc_i(5, 0, 0, 1),          32'h0000_0005, "addi_x1");
        alu_step(enc_i(-3, 0, 0, 2),         32'hFFFF_FFFD, "addi_x2");
        alu_step(enc_r(0, 2, 1, 0, 3),       32'h0000_0002, "add_x3");
        alu_step(enc_r('h20, 1, 2, 0, 4),    32'hFFFF_FFF8, "sub_x4");
        peek(3,  32'h0000_0002, "x3");
        peek(4,  32'hFFFF_FFF8, "x4");
        peek(10, 32'h0000_0000, "x10");
        alu_step(enc_i(1, 1, 0, 1),  32'h0000_0006, "raw_inc1");
        alu_step(enc_i(1, 1, 0, 1),  32'h0000_0007, "raw_inc2");
        alu_step(enc_i(-2, 1, 0, 1), 32'h0000_0005, "raw_dec");
        alu_step(enc_r('h20, 4, 0, 0, 2), 32'h0000_0008, "x2_neg8");
        alu_step(enc_r('h20, 2, 0, 0, 2), 32'hFFFF_FFF8, "x2_back");

        step(enc_b(16, 1, 2, 6),  32'hFFFF_FFF3, exp_pc + 32'd4,  1'b1, "bltu_nt");
        step(enc_b(16, 1, 2, 4),  32'hFFFF_FFF3, exp_pc + 32'd16, 1'b1, "blt_t");
        step(enc_b(16, 1, 2, 5),  32'hFFFF_FFF3, exp_pc + 32'd4,  1'b1, "bge_nt");
        step(enc_b(-12, 1, 2, 7), 32'hFFFF_FFF3, exp_pc - 32'd12, 1'b1, "bgeu_t");
        step(enc_b(8, 2, 1, 1),   32'h0000_000D, exp_pc + 32'd8,  1'b1, "bne_t");
        step(enc_b(8, 2, 1, 2),   32'h0,         exp_pc + 32'd4,  1'b0, "br_undef");

        alu_step(enc_i(7, 0, 0, 0),    32'h0000_0007, "addi_x0");
        alu_step(enc_r(0, 0, 0, 0, 5), 32'h0000_0000, "add_x5");
        peek(0, 32'h0, "x0");
        peek(5, 32'h0, "x5");
        alu_step(enc_u('hABCDE, 6), 32'hABCD_E000, "lui_x6");
        peek(6, 32'hABCD_E000, "x6");

        alu_step(enc_r(0, 1, 2, 2, 7),    32'h0000_0001, "slt");
        alu_step(enc_r(0, 1, 2, 3, 7),    32'h0000_0000, "sltu");
        alu_step(enc_i(-1, 2, 2, 7),      32'h0000_0001, "slti");
        alu_step(enc_i(-1, 1, 3, 10),     32'h0000_0001, "sltiu");
        alu_step(enc_i('h401, 2, 5, 8),   32'hFFFF_FFFC, "srai");
        alu_step(enc_i(28, 2, 5, 9),      32'h0000_000F, "srli");
        alu_step(enc_i(4, 1, 1, 9),       32'h0000_0050, "slli");
        alu_step(enc_i('hFF, 1, 4, 10),   32'h0000_00FA, "xori");
        alu_step(enc_i(-16, 1, 6, 10),    32'hFFFF_FFF5, "ori");
        alu_step(enc_i('hF0, 2, 7, 10),   32'h0000_00F0, "andi");
        alu_step(enc_r(0, 2, 1, 1, 11),   32'h0500_0000, "sll_b40");
        alu_step(enc_r(0, 1, 2, 5, 11),   32'h07FF_FFFF, "srl");
        alu_step(enc_r('h20, 1, 2, 5, 11), 32'hFFFF_FFFF, "sra");
        alu_step(enc_r(0, 2, 1, 7, 11),   32'h0000_0000, "and");
        alu_step(enc_r(0, 2, 1, 6, 11),   32'hFFFF_FFFD, "or");
        alu_step(enc_r(0, 2, 1, 4, 11),   32'hFFFF_FFFD, "xor");
        peek(11, 32'hFFFF_FFFD, "x11");
        alu_step(enc_u('h80000, 12),        32'h8000_0000, "lui_x12");
        alu_step(enc_r(0, 12, 12, 0, 12),   32'h0000_0000, "add_wrap");
        peek(12, 32'h0, "x12");

        step(enc_r(1, 2, 1, 0, 14), 32'h0, exp_pc + 32'd4, 1'b0, "r_undef_f7");
        peek(14, 32'h0, "x14");
        step(enc_i(33, 1, 1, 15),   32'h0, exp_pc + 32'd4, 1'b0, "slli_bad_f7");
        peek(15, 32'h0, "x15");

        jp = exp_pc;
        step(enc_j(8, 13), jp + 32'd4, jp + 32'd8, 1'b1, "jal");
        peek(13, jp + 32'd4, "x13");

        alu_step(enc_i(0, 0, 0, 1),  32'h0, "fib_x1");
        alu_step(enc_i(1, 0, 0, 2),  32'h1, "fib_x2");
        alu_step(enc_i(10, 0, 0, 3), 32'hA, "fib_x3");
        loop_pc = exp_pc;
        prev_x2 = 32'h1;
        for (int i = 0; i < 10; i++) begin
            alu_step(enc_r(0, 2, 1, 0, 4), 32'(fib[i]), "fib_add");
            alu_step(enc_i(0, 2, 0, 1),    prev_x2,     "fib_mv1");
            alu_step(enc_i(0, 4, 0, 2),    32'(fib[i]), "fib_mv2");
            alu_step(enc_i(-1, 3, 0, 3),   32'(9 - i),  "fib_dec");
            step(enc_b(-16, 0, 3, 1), 32'(9 - i),
                 (i < 9) ? loop_pc : exp_pc + 32'd4, 1'b1, "fib_bne");
            prev_x2 = 32'(fib[i]);
        end
        peek(2, 32'd89, "fib_x2_final");
        peek(1, 32'd55, "fib_x1_final");

        arst_n      = 1'b0;
        instruction = enc_i(0, 6, 0, 0);
        #1;
        check("midrst.pc", pc, 32'h0);
        check("midrst.x6", alu_result, 32'h0);
        #2;
        arst_n = 1'b1;
        exp_pc = 32'h0;
        peek(6, 32'h0, "post_rst_x6");
        peek(2, 32'h0, "post_rst_x2");

        step(enc_j(-12, 0), 32'h0000_000C, 32'hFFFF_FFFC, 1'b1, "jal_to_top");
        alu_step(32'h0000_0513, 32'h0, "pc_top");
        alu_step(32'h0000_0513, 32'h0, "pc_wrapped");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/microprocessor_core.md
MICROPROCESSOR_CORE -- requirements
Module: microprocessor_core

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction/register/datapath width.
REQ-002 Parameter REG_COUNT, default 32, number of architectural registers x0..x31.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 arst_n  input  1  reset, asynchronous, active-low.
REQ-006 instruction  input  DATA_WIDTH  RV32I instruction word executed in the current cycle.
REQ-007 pc  output  DATA_WIDTH  current program counter.
REQ-008 alu_result  output  DATA_WIDTH  combinational ALU result of the current instruction.

Function
REQ-009 Single-cycle, non-pipelined core: decode, register read, execute and write-back complete within one clock.
REQ-010 Submodules: PC register, immediate generator, immediate/register operand mux, ALU, 32x32 register file (2 read, 1 write), next-PC mux, control unit.
REQ-011 Control unit decodes opcode=instruction[6:0], funct3=[14:12], funct7=[31:25]; rd=[11:7], rs1=[19:15], rs2=[24:20].
REQ-012 R-type (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; rd <= ALU(rs1, rs2).
REQ-013 I-type ALU (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; rd <= ALU(rs1, sign-extended imm[11:0]); shift amount = imm[4:0].
REQ-014 LUI (0110111): rd <= {instruction[31:12], 12'b0}.
REQ-015 Branches (1100011): BEQ, BNE, BLT, BGE, BLTU, BGEU; B-immediate sign-extended, bit0 = 0; taken -> pc <= pc + imm, else pc <= pc + 4; no register write.
REQ-016 JAL (1101111): rd <= pc + 4; pc <= pc + sign-extended J-immediate.
REQ-017 All other opcodes, and undefined funct3/funct7 combinations: treated as NOP (no register write, pc <= pc + 4).
REQ-018 Arithmetic modulo 2^32; overflow wraps silently; SLT/BLT/BGE signed, SLTU/BLTU/BGEU unsigned.
REQ-019 SRA/SRAI sign-fill; SRL/SRLI zero-fill; shifts use operand B[4:0] only.
REQ-020 alu_result for branches = rs1 - rs2; for JAL = pc + 4; for LUI = U-immediate.
REQ-021 Register x0 reads 0 always; writes to x0 ignored.
REQ-022 Register file reads are combinational; a read of the register written in the same cycle returns the old value (new value visible next cycle).
REQ-023 PC increments by 4 per non-branching instruction and wraps from 32'hFFFF_FFFC to 0.

Reset
REQ-024 arst_n low asynchronously forces pc = RESET_PC and all registers x1..x31 = 0, regardless of clk.
REQ-025 While arst_n low: no register writes, pc held; alu_result remains combinational from the current instruction with zeroed registers.
REQ-026 Deassertion takes effect at the next rising clk edge; the first instruction executes in that cycle.
REQ-027 Reset asserted mid-operation discards all architectural state; no partial write-back.

Verification
REQ-028 Reset then instruction=32'h0000_0513 (ADDI x10,x0,0) -> alu_result=0, x10=0, pc advances 0,4,8,... each cycle.
REQ-029 ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1 -> x3=2, x4=32'hFFFF_FFF8.
REQ-030 Fibonacci sequence via ADDI/ADD/BNE loop (x1=0,x2=1, 10 iterations) -> x2 sequence ends at 89; BNE falls through when count reaches 0.
REQ-031 ADDI x0,x0,7 then ADD x5,x0,x0 -> x5=0 (x0 immutable); LUI x6,0xABCDE -> x6=32'hABCD_E000.
REQ-032 BEQ x0,x0,-8 at pc=16 -> pc=8 next cycle; BLTU x2(=FFFF_FFF8),x1(=5) not taken, BLT taken.
REQ-033 Assert arst_n low for 3 ns between edges mid-program -> pc and all registers read 0 immediately; execution restarts from RESET_PC after release.
